fib_seq_engine: RTL

Parametrised Fibonacci sequencer: an FSM that seeds two registers and fills a register bank so that r[i] = r[i-1] + r[i-2]. It is the self-contained successor to the fixed 16x16 Fibonacci regfile/ALU bring-up bench, and the first sequenced datapath block in the computer. Adds configurable width and depth, term count, start/done handshake, single-step mode and overflow handling. Results are readable through a debug read port for the display and the bench.

---
 rtl/fib_pkg.sv | 24 ++
 rtl/fib_reg_bank.sv | 36 +++
 rtl/fib_seq_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci sequencer: FSM states, overflow modes and the
// term-count clamp.
package fib_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad0,
    StLoad1,
    StCalc,
    StDone
  } fib_state_e;

  localparam int unsigned OVF_WRAP = 0;
  localparam int unsigned OVF_SAT  = 1;

  // Effective term count: never fewer than the two seeds, never more than the bank holds.
  function automatic int unsigned clamp_terms(input int unsigned num_terms,
                                              input int unsigned num_regs);
    if (num_terms < 2) return 2;
    if (num_terms > num_regs) return num_regs;
    return num_terms;
  endfunction

endpackage

// File: rtl/fib_reg_bank.sv
// Register bank for the Fibonacci sequencer: one-hot write enable, shared write data,
// synchronous clear and an asynchronous debug read port.
module fib_reg_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_REGS-1:0] i_we,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic [IDX_W-1:0]    i_rd_addr,
  output logic [WIDTH-1:0]    o_rd_data
);

  logic [WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_reset) begin
        r_mem[k] <= '0;
      end else if (i_we[k]) begin
        r_mem[k] <= i_wdata;
      end
    end
  end

  // Addresses past the bank (non power-of-two depth) read as zero.
  always_comb begin
    o_rd_data = '0;
    if (32'(i_rd_addr) < NUM_REGS) begin
      o_rd_data = r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci sequencer: seeds r0/r1, then fills r[i] = r[i-1] + r[i-2] up to the clamped
// term count, with optional single-stepping and wrap or saturate overflow handling.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned NUM_REGS = 16,
  parameter  int unsigned OVF_MODE = OVF_WRAP,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_step_mode,
  input  logic                i_step,
  input  logic [WIDTH-1:0]    i_seed0,
  input  logic [WIDTH-1:0]    i_seed1,
  input  logic [IDX_W:0]      i_num_terms,
  input  logic [IDX_W-1:0]    i_rd_addr,
  output logic [WIDTH-1:0]    o_rd_data,
  output logic [NUM_REGS-1:0] o_reg_enable,
  output logic [IDX_W-1:0]    o_cur_index,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow
);

  fib_state_e       r_state;
  logic             r_step_mode;
  logic [WIDTH-1:0] r_seed0, r_seed1;
  logic [WIDTH-1:0] r_prev1, r_prev2;
  logic [IDX_W-1:0] r_idx, r_last_idx, r_cur_index;
  logic             r_busy, r_done, r_overflow;

  logic [WIDTH:0]      w_sum;
  logic                w_carry;
  logic                w_sat;
  logic                w_wr;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [WIDTH-1:0]    w_wdata;
  logic [NUM_REGS-1:0] w_we;

  // Writes are strictly sequential, so the last two written values are r[i-1] and r[i-2].
  assign w_sum   = {1'b0, r_prev1} + {1'b0, r_prev2};
  assign w_carry = w_sum[WIDTH];
  assign w_sat   = w_carry && (OVF_MODE == OVF_SAT);

  always_comb begin
    w_wr     = 1'b0;
    w_wr_idx = '0;
    w_wdata  = '0;
    case (r_state)
      StLoad0: begin
        w_wr    = 1'b1;
        w_wdata = r_seed0;
      end
      StLoad1: begin
        w_wr     = 1'b1;
        w_wr_idx = IDX_W'(1);
        w_wdata  = r_seed1;
      end
      StCalc: begin
        w_wr     = !r_step_mode || i_step;
        w_wr_idx = r_idx;
        w_wdata  = w_sat ? '1 : w_sum[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign w_we = w_wr ? (NUM_REGS'(1) << w_wr_idx) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_step_mode <= 1'b0;
      r_seed0     <= '0;
      r_seed1     <= '0;
      r_prev1     <= '0;
      r_prev2     <= '0;
      r_idx       <= '0;
      r_last_idx  <= '0;
      r_cur_index <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_prev2     <= r_prev1;
        r_prev1     <= w_wdata;
        r_cur_index <= w_wr_idx;
      end
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_seed0     <= i_seed0;
            r_seed1     <= i_seed1;
            r_step_mode <= i_step_mode;
            r_last_idx  <= IDX_W'(clamp_terms(32'(i_num_terms), NUM_REGS) - 1);
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= StLoad0;
          end
        end
        StLoad0: r_state <= StLoad1;
        StLoad1: begin
          if (r_last_idx == IDX_W'(1)) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= StCalc;
            r_idx   <= IDX_W'(2);
          end
        end
        StCalc: begin
          if (w_wr) begin
            if (w_carry) r_overflow <= 1'b1;
            if (w_sat || (r_idx == r_last_idx)) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  fib_reg_bank #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (w_we),
    .i_wdata   (w_wdata),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_reg_enable = w_we;
  assign o_cur_index  = r_cur_index;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;

endmodule
